// File: rtl/regfile_writeback.sv
// Register file write port: merges ALU and load writebacks into an in-order FIFO,
// retires one write per cycle and forwards pending values to the read stage.
module regfile_writeback #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Alu_Valid,
  output logic                    Alu_Ready,
  input  logic [ADDR_WIDTH-1:0]   Alu_Rd,
  input  logic [DATA_WIDTH-1:0]   Alu_Data,
  input  logic                    Mem_Valid,
  output logic                    Mem_Ready,
  input  logic [ADDR_WIDTH-1:0]   Mem_Rd,
  input  logic [DATA_WIDTH-1:0]   Mem_Data,
  output logic                    Write_Register,
  output logic [ADDR_WIDTH-1:0]   Write_Addr,
  output logic [DATA_WIDTH-1:0]   Write_Data,
  input  logic [ADDR_WIDTH-1:0]   Lookup_Addr,
  output logic                    Lookup_Hit,
  output logic [DATA_WIDTH-1:0]   Lookup_Data,
  output logic [$clog2(DEPTH):0]  Pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       free;
  logic                wr_en_q, wr_en_d;
  wb_ent_t             wr_q, wr_d;
  logic                mem_push, alu_push, pop;

  // Ready looks only at the registered count; a same-cycle pop never creates room.
  assign free = CW'(DEPTH) - count_q;

  always_comb begin
    Mem_Ready = 1'b0;
    Alu_Ready = 1'b0;
    if (!Reset) begin
      Mem_Ready = (free >= CW'(1));
      Alu_Ready = (free >= CW'(2)) || ((free == CW'(1)) && !Mem_Valid);
    end
  end

  // Rd==0 completes the handshake but is never queued.
  assign mem_push = Mem_Valid && Mem_Ready && (Mem_Rd != '0);
  assign alu_push = Alu_Valid && Alu_Ready && (Alu_Rd != '0);
  assign pop      = (count_q != '0);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en_d  = 1'b0;
    wr_d     = wr_q;
    if (pop) begin
      wr_en_d  = 1'b1;
      wr_d     = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Mem is older than ALU when both land on the same edge.
    if (mem_push) begin
      fifo_d[wr_ptr_d] = '{rd: Mem_Rd, data: Mem_Data};
      wr_ptr_d         = wr_ptr_d + PW'(1);
    end
    if (alu_push) begin
      fifo_d[wr_ptr_d] = '{rd: Alu_Rd, data: Alu_Data};
      wr_ptr_d         = wr_ptr_d + PW'(1);
    end
    count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_en_q  <= 1'b0;
      wr_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_en_q  <= wr_en_d;
      wr_q     <= wr_d;
    end
  end

  // Entry storage needs no reset: validity comes from count and pointers.
  always_ff @(posedge Clock) begin
    fifo_q <= fifo_d;
  end

  // Walk oldest to youngest so the newest match overrides; output register is oldest of all.
  always_comb begin
    Lookup_Hit  = 1'b0;
    Lookup_Data = '0;
    if (Lookup_Addr != '0) begin
      if (wr_en_q && (wr_q.rd == Lookup_Addr)) begin
        Lookup_Hit  = 1'b1;
        Lookup_Data = wr_q.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count_q) && (fifo_q[rd_ptr_q + PW'(i)].rd == Lookup_Addr)) begin
          Lookup_Hit  = 1'b1;
          Lookup_Data = fifo_q[rd_ptr_q + PW'(i)].data;
        end
      end
    end
  end

  assign Write_Register = wr_en_q;
  assign Write_Addr     = wr_q.rd;
  assign Write_Data     = wr_q.data;
  assign Pending        = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: scenario tasks plus a scoreboard of accepted writes
// compared against every Write_Register pulse.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Alu_Valid, Alu_Ready, Mem_Valid, Mem_Ready;
  logic [AW-1:0] Alu_Rd, Mem_Rd, Write_Addr, Lookup_Addr;
  logic [DW-1:0] Alu_Data, Mem_Data, Write_Data, Lookup_Data;
  logic          Write_Register, Lookup_Hit;
  logic [2:0]    Pending;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   nwrites = 0;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Rd(Alu_Rd), .Alu_Data(Alu_Data),
    .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready), .Mem_Rd(Mem_Rd), .Mem_Data(Mem_Data),
    .Write_Register(Write_Register), .Write_Addr(Write_Addr), .Write_Data(Write_Data),
    .Lookup_Addr(Lookup_Addr), .Lookup_Hit(Lookup_Hit), .Lookup_Data(Lookup_Data),
    .Pending(Pending)
  );

  always #5 Clock = ~Clock;

  // One clock step: at the falling edge compare any retiring write with the scoreboard,
  // then record what the upcoming rising edge will accept.
  task automatic tick();
    exp_t e;
    @(negedge Clock);
    if (Write_Register === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_write got addr=%0d data=%h, expected no write", Write_Addr, Write_Data);
      end else begin
        e = sb_q.pop_front();
        nwrites++;
        if (Write_Addr !== e.rd || Write_Data !== e.data) begin
          bad++;
          $display("FAIL sb_write got addr=%0d data=%h, expected addr=%0d data=%h",
                   Write_Addr, Write_Data, e.rd, e.data);
        end
      end
    end
    if (Reset) sb_q.delete();
    else begin
      if (Mem_Valid && Mem_Ready && Mem_Rd != 0) sb_q.push_back('{rd: Mem_Rd, data: Mem_Data});
      if (Alu_Valid && Alu_Ready && Alu_Rd != 0) sb_q.push_back('{rd: Alu_Rd, data: Alu_Data});
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Alu_Valid = 1'b0;
    Mem_Valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle(); Lookup_Addr = '0;
    Alu_Rd = '0; Alu_Data = '0; Mem_Rd = '0; Mem_Data = '0;
    tick(); tick();
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", Pending); end
    total++; if (Write_Register !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", Write_Register); end
    total++; if (Write_Addr !== '0 || Write_Data !== '0) begin bad++; $display("FAIL rst_wr_ad got=%0d/%h exp=0/0", Write_Addr, Write_Data); end
    Alu_Valid = 1'b1; Mem_Valid = 1'b1; Alu_Rd = 5'd9; Mem_Rd = 5'd9; #1;
    total++; if (Mem_Ready !== 1'b0 || Alu_Ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b%b exp=00", Mem_Ready, Alu_Ready); end
    tick();
    Reset = 1'b0; idle(); #1;
    total++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b%b exp=11", Mem_Ready, Alu_Ready); end
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", Pending); end
  endtask

  task automatic test_single();
    Alu_Valid = 1'b1; Alu_Rd = 5'd5; Alu_Data = 32'h12345678;
    tick(); idle();
    total++; if (Pending !== 3'd1) begin bad++; $display("FAIL single_pend1 got=%0d exp=1", Pending); end
    tick();
    total++; if (Write_Register !== 1'b1 || Write_Addr !== 5'd5 || Write_Data !== 32'h12345678) begin
      bad++; $display("FAIL single_wr got=%b/%0d/%h exp=1/5/12345678", Write_Register, Write_Addr, Write_Data); end
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL single_pend0 got=%0d exp=0", Pending); end
    tick();
    total++; if (Write_Register !== 1'b0 || Write_Addr !== 5'd5) begin
      bad++; $display("FAIL single_idle got=%b/%0d exp=0/5", Write_Register, Write_Addr); end
  endtask

  task automatic test_both();
    Mem_Valid = 1'b1; Mem_Rd = 5'd3; Mem_Data = 32'hAAAA0000;
    Alu_Valid = 1'b1; Alu_Rd = 5'd3; Alu_Data = 32'h00005555; #1;
    total++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b1) begin bad++; $display("FAIL both_ready got=%b%b exp=11", Mem_Ready, Alu_Ready); end
    tick(); idle(); Lookup_Addr = 5'd3; #1;
    total++; if (Pending !== 3'd2) begin bad++; $display("FAIL both_pend got=%0d exp=2", Pending); end
    total++; if (Lookup_Hit !== 1'b1 || Lookup_Data !== 32'h00005555) begin bad++; $display("FAIL both_lk0 got=%b/%h exp=1/00005555", Lookup_Hit, Lookup_Data); end
    tick();
    total++; if (Write_Addr !== 5'd3 || Write_Data !== 32'hAAAA0000) begin bad++; $display("FAIL both_first got=%0d/%h exp=3/aaaa0000", Write_Addr, Write_Data); end
    total++; if (Lookup_Hit !== 1'b1 || Lookup_Data !== 32'h00005555) begin bad++; $display("FAIL both_lk1 got=%b/%h exp=1/00005555", Lookup_Hit, Lookup_Data); end
    tick();
    total++; if (Lookup_Hit !== 1'b1 || Lookup_Data !== 32'h00005555) begin bad++; $display("FAIL both_lk2 got=%b/%h exp=1/00005555", Lookup_Hit, Lookup_Data); end
    tick();
    total++; if (Lookup_Hit !== 1'b0 || Lookup_Data !== '0) begin bad++; $display("FAIL both_lk3 got=%b/%h exp=0/0", Lookup_Hit, Lookup_Data); end
    Lookup_Addr = '0;
  endtask

  // With one pop per cycle the occupancy settles at DEPTH-1, leaving one slot that Mem owns.
  task automatic test_full();
    for (int k = 0; k < 6; k++) begin
      Mem_Valid = 1'b1; Mem_Rd = 5'(8 + 2 * k); Mem_Data = 32'hF000_0000 + 32'(k);
      Alu_Valid = 1'b1; Alu_Rd = 5'(9 + 2 * k); Alu_Data = 32'h0F00_0000 + 32'(k);
      tick();
      total++; if (Pending > 3'(DEPTH)) begin bad++; $display("FAIL full_bound got=%0d exp<=%0d", Pending, DEPTH); end
    end
    total++; if (Pending !== 3'd3) begin bad++; $display("FAIL full_pend got=%0d exp=3", Pending); end
    total++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b%b exp=10", Mem_Ready, Alu_Ready); end
    Mem_Valid = 1'b0; #1;
    total++; if (Alu_Ready !== 1'b1) begin bad++; $display("FAIL full_alu_last got=%b exp=1", Alu_Ready); end
    idle();
    for (int k = 0; k < 5; k++) tick();
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", Pending); end
  endtask

  task automatic test_rd0();
    Alu_Valid = 1'b1; Alu_Rd = '0; Alu_Data = 32'hFFFFFFFF;
    Mem_Valid = 1'b1; Mem_Rd = '0; Mem_Data = 32'hFFFFFFFF; #1;
    total++; if (Alu_Ready !== 1'b1 || Mem_Ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b%b exp=11", Mem_Ready, Alu_Ready); end
    tick(); idle(); Lookup_Addr = '0; #1;
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL rd0_pend got=%0d exp=0", Pending); end
    total++; if (Lookup_Hit !== 1'b0 || Lookup_Data !== '0) begin bad++; $display("FAIL rd0_lookup got=%b/%h exp=0/0", Lookup_Hit, Lookup_Data); end
    tick();
    total++; if (Write_Register !== 1'b0) begin bad++; $display("FAIL rd0_nowrite got=%b exp=0", Write_Register); end
  endtask

  task automatic test_reset_mid();
    Mem_Valid = 1'b1; Mem_Rd = 5'd1; Mem_Data = 32'h11;
    Alu_Valid = 1'b1; Alu_Rd = 5'd2; Alu_Data = 32'h22;
    tick();
    Mem_Valid = 1'b0; Alu_Rd = 5'd3; Alu_Data = 32'h33;
    tick();
    total++; if (Write_Register !== 1'b1 || Write_Addr !== 5'd1) begin bad++; $display("FAIL rmid_first got=%b/%0d exp=1/1", Write_Register, Write_Addr); end
    idle(); Reset = 1'b1; Mem_Valid = 1'b1; Mem_Rd = 5'd4; Mem_Data = 32'h44;
    tick();
    Reset = 1'b0; idle(); #1;
    total++; if (Write_Register !== 1'b0) begin bad++; $display("FAIL rmid_wr got=%b exp=0", Write_Register); end
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL rmid_pend got=%0d exp=0", Pending); end
    for (int r = 1; r <= 3; r++) begin
      Lookup_Addr = 5'(r); #1;
      total++; if (Lookup_Hit !== 1'b0) begin bad++; $display("FAIL rmid_lookup rd=%0d got=%b exp=0", r, Lookup_Hit); end
    end
    Lookup_Addr = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (Write_Register !== 1'b0) begin bad++; $display("FAIL rmid_quiet got=%b exp=0", Write_Register); end
    end
  endtask

  task automatic test_stream();
    int base;
    base = nwrites;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i % 2 == 0) begin
        Mem_Valid = 1'b1; Mem_Rd = 5'((i * 7) % 31 + 1); Mem_Data = $urandom;
      end else begin
        Alu_Valid = 1'b1; Alu_Rd = 5'((i * 7) % 31 + 1); Alu_Data = $urandom;
      end
      #1;
      total++; if ((Mem_Valid && !Mem_Ready) || (Alu_Valid && !Alu_Ready)) begin
        bad++; $display("FAIL stream_ready i=%0d got=%b%b exp=accept", i, Mem_Ready, Alu_Ready); end
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) tick();
    total++; if (nwrites - base !== 12) begin bad++; $display("FAIL stream_count got=%0d exp=12", nwrites - base); end
    total++; if (Pending !== 3'd0) begin bad++; $display("FAIL stream_pend got=%0d exp=0", Pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_full();
    test_rd0();
    test_reset_mid();
    test_stream();
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
